mmio_interconnect: RTL and testbench
====================================

# mmio_interconnect

Parametrised memory-mapped I/O interconnect between the PUC_RS5 data port and N peripheral slaves (RAM, RTC, debug/console, timer, ...). Replaces the fixed three-way nibble decoder and single-cycle registered read mux with per-slave base/mask regions, per-slave read latency and core stall generation. Unmapped accesses return a default word and latch a sticky error with the faulting address.

## Interface
Parameters:
- N_SLAVES, 4, number of slave channels (1..16)
- BASE_ADDR, {32'h8000_0000, 32'h4000_0000, 32'h2000_0000, 32'h0000_0000}, packed N_SLAVES×32; entry k is slave k base
- ADDR_MASK, {4{32'hF000_0000}}, packed N_SLAVES×32; slave k hits when (addr_i & ADDR_MASK[k]) == BASE_ADDR[k]
- RD_LATENCY, {4{4'd1}}, packed N_SLAVES×4; cycles from read accept to slave data valid (0 treated as 1)
- DEFAULT_RDATA, 32'hDEAD_BEEF, read data returned for unmapped reads

Ports:
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  reset; one clock; reset is asynchronous and active-low
- req_i  in  1  core data-port operation enable
- we_i  in  4  byte write enables; '0 = read
- addr_i  in  32  core address
- wdata_i  in  32  core write data
- rdata_o  out  32  read data to core
- stall_o  out  1  hold core while a multi-cycle read is outstanding
- sel_o  out  N_SLAVES  one-hot slave select (combinational, accept cycle only)
- we_o  out  4  we_i forwarded
- addr_o  out  32  addr_i forwarded
- wdata_o  out  32  wdata_i forwarded
- rdata_i  in  N_SLAVES×32  slave read data, slice k from slave k
- err_valid_o  out  1  sticky unmapped-access flag
- err_addr_o  out  32  address of first unmapped access since last clear
- err_clr_i  in  1  clears err_valid_o/err_addr_o

## Operation
- FSM: IDLE, WAIT. Accept = req_i in IDLE (stall_o low).
- Decode: lowest-index hitting slave wins on overlap; sel_o one-hot to it in the accept cycle only; zero otherwise and in WAIT.
- Write (we_i != 0): posted, never stalls; sel_o pulse only.
- Read, slave k, L = max(RD_LATENCY[k],1): L = 1 stays IDLE; L > 1 -> WAIT, 4-bit down-counter loaded with L-1, registered slave index kept.
- WAIT: stall_o high; req_i ignored; counter decrements each cycle; at 1 -> IDLE.
- rdata_o = rdata_i[k] only in the completion cycle (accept + L); 0 in every other cycle.
- Unmapped access (no hit, read or write): no sel_o. Read returns DEFAULT_RDATA in accept+1, no stall. If err_valid_o low: set, err_addr_o <= addr_i. If already set: unchanged (first error kept).
- err_clr_i clears both; simultaneous clear and new unmapped access -> new error captured (set wins).
- we_o/addr_o/wdata_o are combinational pass-throughs.

## Timing
- Reset values: state IDLE, stall_o 0, rdata_o 0, err_valid_o 0, err_addr_o 0, counter 0, registered index 0; sel_o 0 only if req_i low.
- Reset mid-WAIT: pending read dropped, stall_o low on reset assertion (asynchronous), no late rdata_o.
- Read latency to core: L cycles; stall_o high exactly L-1 cycles (accept+1 .. accept+L-1), low in completion cycle.
- Back-to-back L=1 reads: accept every cycle, rdata_o each following cycle.
- Read accept allowed in the completion cycle of the previous read (state returns IDLE that cycle).
- Slave data must be stable on rdata_i[k] at accept+L; interconnect samples nothing earlier.

## Test plan
- Defaults, read 0x0000_0010 with rdata_i[0]=0x1234_5678 -> sel_o=0001 in cycle T, rdata_o=0x1234_5678 at T+1, stall_o never high.
- RD_LATENCY[2]=4, read 0x2000_0004 at T -> sel_o=0100 at T only, stall_o high T+1..T+3, rdata_o=rdata_i[2] at T+4, req_i pulses during WAIT produce no sel_o.
- Write 0x8000_1000, we_i=4'b0001, wdata 0x41 -> sel_o=1000, we_o/wdata_o forwarded, no stall, rdata_o stays 0.
- Read 0xA000_0000 (BASE_ADDR[3]=0x8000_0000, mask 0xF000_0000, unmapped) -> sel_o=0, rdata_o=0xDEAD_BEEF at T+1, err_valid_o=1, err_addr_o=0xA000_0000; second unmapped 0xC000_0000 leaves err_addr_o unchanged; err_clr_i concurrent with a third unmapped 0xE000_0000 -> err_valid_o=1, err_addr_o=0xE000_0000.
- Overlapping regions (slaves 1 and 3 both hit 0x4000_0000) -> sel_o=0010 only.
- rst_ni low at T+2 of a latency-4 read -> stall_o 0 immediately, state IDLE, rdata_o 0 at T+4, next read accepted normally after release.

Source files
------------

// File: rtl/mmio_interconnect_if.sv
// Core data port and slave-side bus of the MMIO interconnect, bundled for
// module connection.
interface mmio_interconnect_if #(
    parameter int unsigned N_SLAVES = 4
);
    logic                     req_i;
    logic [3:0]               we_i;
    logic [31:0]              addr_i;
    logic [31:0]              wdata_i;
    logic [31:0]              rdata_o;
    logic                     stall_o;
    logic [N_SLAVES-1:0]      sel_o;
    logic [3:0]               we_o;
    logic [31:0]              addr_o;
    logic [31:0]              wdata_o;
    logic [N_SLAVES*32-1:0]   rdata_i;
    logic                     err_valid_o;
    logic [31:0]              err_addr_o;
    logic                     err_clr_i;

    modport slave (
        input  req_i, we_i, addr_i, wdata_i, rdata_i, err_clr_i,
        output rdata_o, stall_o, sel_o, we_o, addr_o, wdata_o,
               err_valid_o, err_addr_o
    );

    modport master (
        output req_i, we_i, addr_i, wdata_i, rdata_i, err_clr_i,
        input  rdata_o, stall_o, sel_o, we_o, addr_o, wdata_o,
               err_valid_o, err_addr_o
    );
endinterface

// File: rtl/mmio_interconnect.sv
// Base/mask address decoder between the core data port and N slaves, with
// per-slave read latency, core stall and sticky unmapped-access capture.
module mmio_interconnect #(
    parameter int unsigned             N_SLAVES      = 4,
    parameter logic [N_SLAVES*32-1:0]  BASE_ADDR     = {32'h8000_0000, 32'h4000_0000,
                                                        32'h2000_0000, 32'h0000_0000},
    parameter logic [N_SLAVES*32-1:0]  ADDR_MASK     = {4{32'hF000_0000}},
    parameter logic [N_SLAVES*4-1:0]   RD_LATENCY    = {4{4'd1}},
    parameter logic [31:0]             DEFAULT_RDATA = 32'hDEAD_BEEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    mmio_interconnect_if.slave bus
);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  idx_q, idx_d;
    logic        done_q, done_d;
    logic        dflt_q, dflt_d;
    logic        err_valid_q, err_valid_d;
    logic [31:0] err_addr_q, err_addr_d;

    logic        hit;
    logic [3:0]  hit_idx;
    logic [3:0]  hit_lat;
    logic        accept;
    logic        is_read;
    logic [31:0] slv_data;

    // Scan upward and keep the first match so the lowest index wins overlaps.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        hit_lat = 4'd1;
        for (int unsigned k = 0; k < N_SLAVES; k++) begin
            if (!hit && ((bus.addr_i & ADDR_MASK[32*k +: 32]) == BASE_ADDR[32*k +: 32])) begin
                hit     = 1'b1;
                hit_idx = 4'(k);
                hit_lat = (RD_LATENCY[4*k +: 4] == 4'd0) ? 4'd1 : RD_LATENCY[4*k +: 4];
            end
        end
    end

    assign accept  = bus.req_i && (state_q == IDLE);
    assign is_read = (bus.we_i == '0);

    always_comb begin
        bus.sel_o = '0;
        slv_data  = '0;
        for (int unsigned k = 0; k < N_SLAVES; k++) begin
            bus.sel_o[k] = accept && hit && (hit_idx == 4'(k));
            if (idx_q == 4'(k)) begin
                slv_data = bus.rdata_i[32*k +: 32];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
            dflt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            dflt_q  <= dflt_d;
        end
    end

    // done_d marks the next cycle as the completion cycle of a mapped read.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        dflt_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept && is_read) begin
                    if (hit) begin
                        idx_d = hit_idx;
                        if (hit_lat == 4'd1) begin
                            done_d = 1'b1;
                        end else begin
                            state_d = WAIT;
                            cnt_d   = hit_lat - 4'd1;
                        end
                    end else begin
                        dflt_d = 1'b1;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A new unmapped access outranks a concurrent clear.
    always_comb begin
        err_valid_d = err_valid_q;
        err_addr_d  = err_addr_q;
        if (accept && !hit && (!err_valid_q || bus.err_clr_i)) begin
            err_valid_d = 1'b1;
            err_addr_d  = bus.addr_i;
        end else if (bus.err_clr_i) begin
            err_valid_d = 1'b0;
            err_addr_d  = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_valid_q <= 1'b0;
            err_addr_q  <= '0;
        end else begin
            err_valid_q <= err_valid_d;
            err_addr_q  <= err_addr_d;
        end
    end

    assign bus.stall_o     = (state_q == WAIT);
    assign bus.rdata_o     = done_q ? slv_data : (dflt_q ? DEFAULT_RDATA : '0);
    assign bus.err_valid_o = err_valid_q;
    assign bus.err_addr_o  = err_addr_q;
    assign bus.we_o        = bus.we_i;
    assign bus.addr_o      = bus.addr_i;
    assign bus.wdata_o     = bus.wdata_i;

endmodule

// File: tb/tb_mmio_interconnect.sv
// Directed scoreboard bench: stimulus queues expected sel/rdata/stall-run
// values, a negedge monitor pops and compares whenever the DUT presents them.
module tb_mmio_interconnect;

    localparam logic [31:0] D0 = 32'h1234_5678;
    localparam logic [31:0] D1 = 32'h1111_0001;
    localparam logic [31:0] D2 = 32'h2222_0002;
    localparam logic [31:0] D3 = 32'h3333_0003;

    logic clk;
    logic rst_n;

    int total = 0;
    int bad   = 0;

    logic [3:0]  exp_sel[$];
    logic [31:0] exp_rdata[$];
    int          exp_stall[$];
    int          stall_run = 0;

    mmio_interconnect_if #(.N_SLAVES(4)) bus ();
    mmio_interconnect_if #(.N_SLAVES(4)) ovl ();

    // Slave 0 @0x0, slave 1 @0x4, slave 2 @0x2 (latency 4), slave 3 @0x8.
    mmio_interconnect #(
        .N_SLAVES     (4),
        .BASE_ADDR    ({32'h8000_0000, 32'h2000_0000, 32'h4000_0000, 32'h0000_0000}),
        .ADDR_MASK    ({4{32'hF000_0000}}),
        .RD_LATENCY   ({4'd1, 4'd4, 4'd1, 4'd1}),
        .DEFAULT_RDATA(32'hDEAD_BEEF)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    // Slaves 1 and 3 both decode 0x4000_0000.
    mmio_interconnect #(
        .N_SLAVES     (4),
        .BASE_ADDR    ({32'h4000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000}),
        .ADDR_MASK    ({4{32'hF000_0000}}),
        .RD_LATENCY   ({4{4'd1}}),
        .DEFAULT_RDATA(32'hDEAD_BEEF)
    ) dut_ovl (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (ovl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (bus.sel_o !== 4'b0000) begin
            total++;
            if (exp_sel.size() == 0) begin
                bad++;
                $display("FAIL sel_unexpected got=%b want=0000", bus.sel_o);
            end else begin
                logic [3:0] e;
                e = exp_sel.pop_front();
                if (bus.sel_o !== e) begin
                    bad++;
                    $display("FAIL sel got=%b want=%b", bus.sel_o, e);
                end
            end
        end
        if (bus.rdata_o !== 32'h0) begin
            total++;
            if (exp_rdata.size() == 0) begin
                bad++;
                $display("FAIL rdata_unexpected got=%h want=0", bus.rdata_o);
            end else begin
                logic [31:0] e;
                e = exp_rdata.pop_front();
                if (bus.rdata_o !== e) begin
                    bad++;
                    $display("FAIL rdata got=%h want=%h", bus.rdata_o, e);
                end
            end
        end
        if (bus.stall_o === 1'b1) begin
            stall_run++;
        end else if (stall_run != 0) begin
            total++;
            if (exp_stall.size() == 0) begin
                bad++;
                $display("FAIL stall_unexpected got=%0d cycles want=none", stall_run);
            end else begin
                int e;
                e = exp_stall.pop_front();
                if (stall_run != e) begin
                    bad++;
                    $display("FAIL stall_len got=%0d want=%0d", stall_run, e);
                end
            end
            stall_run = 0;
        end
    end

    initial begin
        rst_n          = 1'b0;
        bus.req_i      = 1'b0;
        bus.we_i       = 4'h0;
        bus.addr_i     = '0;
        bus.wdata_i    = '0;
        bus.err_clr_i  = 1'b0;
        bus.rdata_i    = {D3, D2, D1, D0};
        ovl.req_i      = 1'b0;
        ovl.we_i       = 4'h0;
        ovl.addr_i     = '0;
        ovl.wdata_i    = '0;
        ovl.err_clr_i  = 1'b0;
        ovl.rdata_i    = '0;

        #2;
        check("rst_stall", 32'(bus.stall_o), 32'h0);
        check("rst_rdata", bus.rdata_o, 32'h0);
        check("rst_err_valid", 32'(bus.err_valid_o), 32'h0);
        check("rst_err_addr", bus.err_addr_o, 32'h0);
        check("rst_sel", 32'(bus.sel_o), 32'h0);
        cycle();
        cycle();
        rst_n = 1'b1;
        cycle();

        // Latency-1 read, then back-to-back latency-1 reads
        bus.req_i = 1'b1; bus.addr_i = 32'h0000_0010;
        exp_sel.push_back(4'b0001); exp_rdata.push_back(D0);
        cycle();
        bus.addr_i = 32'h8000_0020;
        exp_sel.push_back(4'b1000); exp_rdata.push_back(D3);
        cycle();
        bus.addr_i = 32'h4000_0008;
        exp_sel.push_back(4'b0010); exp_rdata.push_back(D1);
        cycle();
        bus.req_i = 1'b0;
        cycle();
        cycle();

        // Latency-4 read, req pulses during WAIT, accept in completion cycle
        bus.req_i = 1'b1; bus.addr_i = 32'h2000_0004;
        exp_sel.push_back(4'b0100); exp_stall.push_back(3); exp_rdata.push_back(D2);
        cycle();
        bus.addr_i = 32'h0000_0010;
        cycle();
        bus.req_i = 1'b0;
        cycle();
        bus.req_i = 1'b1;
        cycle();
        exp_sel.push_back(4'b0001); exp_rdata.push_back(D0);
        cycle();
        bus.req_i = 1'b0;
        cycle();
        cycle();

        // Posted write
        bus.req_i = 1'b1; bus.addr_i = 32'h8000_1000; bus.we_i = 4'b0001; bus.wdata_i = 32'h41;
        exp_sel.push_back(4'b1000);
        #1;
        check("we_fwd", 32'(bus.we_o), 32'h1);
        check("wdata_fwd", bus.wdata_o, 32'h41);
        check("addr_fwd", bus.addr_o, 32'h8000_1000);
        cycle();
        bus.req_i = 1'b0; bus.we_i = 4'h0; bus.wdata_i = '0;
        cycle();
        cycle();

        // Unmapped accesses and sticky error
        bus.req_i = 1'b1; bus.addr_i = 32'hA000_0000;
        exp_rdata.push_back(32'hDEAD_BEEF);
        cycle();
        bus.req_i = 1'b0;
        check("err_valid_first", 32'(bus.err_valid_o), 32'h1);
        check("err_addr_first", bus.err_addr_o, 32'hA000_0000);
        cycle();
        bus.req_i = 1'b1; bus.addr_i = 32'hC000_0000; bus.we_i = 4'hF;
        cycle();
        bus.req_i = 1'b0; bus.we_i = 4'h0;
        check("err_addr_kept", bus.err_addr_o, 32'hA000_0000);
        cycle();
        bus.req_i = 1'b1; bus.addr_i = 32'hE000_0000; bus.err_clr_i = 1'b1;
        exp_rdata.push_back(32'hDEAD_BEEF);
        cycle();
        bus.req_i = 1'b0; bus.err_clr_i = 1'b0;
        check("err_valid_clr_set", 32'(bus.err_valid_o), 32'h1);
        check("err_addr_clr_set", bus.err_addr_o, 32'hE000_0000);
        cycle();
        bus.err_clr_i = 1'b1;
        cycle();
        bus.err_clr_i = 1'b0;
        check("err_valid_cleared", 32'(bus.err_valid_o), 32'h0);
        check("err_addr_cleared", bus.err_addr_o, 32'h0);

        // Overlapping regions: lowest index wins
        ovl.req_i = 1'b1; ovl.addr_i = 32'h4000_0000;
        #1;
        check("ovl_sel", 32'(ovl.sel_o), 32'b0010);
        cycle();
        ovl.req_i = 1'b0;
        cycle();

        // Reset in the middle of a latency-4 read
        bus.req_i = 1'b1; bus.addr_i = 32'h2000_0004;
        exp_sel.push_back(4'b0100); exp_stall.push_back(1);
        cycle();
        bus.req_i = 1'b0;
        cycle();
        rst_n = 1'b0;
        #1;
        check("rst_mid_stall", 32'(bus.stall_o), 32'h0);
        cycle();
        cycle();
        check("rst_mid_rdata", bus.rdata_o, 32'h0);
        rst_n = 1'b1;
        cycle();
        bus.req_i = 1'b1; bus.addr_i = 32'h2000_0004;
        exp_sel.push_back(4'b0100); exp_stall.push_back(3); exp_rdata.push_back(D2);
        cycle();
        bus.req_i = 1'b0;
        repeat (6) cycle();

        check("sel_queue_left", 32'(exp_sel.size()), 32'h0);
        check("rdata_queue_left", 32'(exp_rdata.size()), 32'h0);
        check("stall_queue_left", 32'(exp_stall.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
